iter_root_unit: RTL and testbench
=================================

ITER_ROOT_UNIT -- requirements
Module: iter_root_unit

Interface
REQ-001 Parameter WIDTH, 8, operand/result width; SHALL be even and >= 4.
REQ-002 Derived N_SQ = WIDTH/2, N_CB = ceil(WIDTH/3), SW = clog2(N_SQ+1); SHALL not be overridable.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 x  input  WIDTH  unsigned operand, sampled only at launch.
REQ-006 on  input  2  mode/enable: 0 off, 1 integer sqrt, 2 integer cube root, 3 pass-through.
REQ-007 start  input  1  launch request, level-sampled.
REQ-008 y  output  WIDTH  registered result, zero-extended.
REQ-009 s  output  SW  iteration step counter.
REQ-010 b  output  1  busy.
REQ-011 active  output  1  registered copy of (on != 0).
REQ-012 regime  output  2  mode latched at last launch.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 States IDLE, CALC, DONE; b SHALL be 1 exactly in CALC.
REQ-015 Launch: in IDLE or DONE, start=1 and on!=0 -> latch x, regime<=on, s<=0, clear work accumulator, go CALC.
REQ-016 start with on=0 SHALL be ignored; start in CALC SHALL be ignored.
REQ-017 Iterations per op: N_SQ for mode 1, N_CB for mode 2, 1 for mode 3.
REQ-018 Each CALC cycle SHALL resolve one result bit MSB-first (sqrt: keep bit if cand^2 <= xr; cbrt: keep bit if cand^3 <= xr) and increment s.
REQ-019 Comparisons SHALL use full-precision products (2*N_SQ and 3*N_CB bits); no overflow truncation.
REQ-020 After last iteration: y<=floor root (mode 1/2) or xr (mode 3), go DONE, done=1 for that cycle only.
REQ-021 Latency: launch at edge k -> y valid and done=1 after edge k+N+1; for WIDTH=8 sqrt done 5 cycles after launch edge.
REQ-022 s SHALL hold final count N after completion until next launch.
REQ-023 y SHALL change only at completion; holds value through subsequent ops and aborts.
REQ-024 x/on changes during CALC SHALL not affect the op, except on=0 which aborts: next state IDLE, b=0, no done, y and s unchanged.
REQ-025 Back-to-back: start=1 and on!=0 in DONE cycle SHALL launch next op immediately (no IDLE cycle).
REQ-026 DONE with no valid start SHALL go to IDLE.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, y=0, s=0, b=0, done=0, active=0, regime=0, regardless of state.
REQ-028 rst mid-CALC SHALL discard the op without done pulse; rst SHALL take priority over start.

Configuration
REQ-029 Macro ITER_ROOT_UNIT_REMAINDER_EN SHALL, when defined, add output rem (WIDTH, registered): xr - y^2 (mode 1), xr - y^3 (mode 2), 0 (mode 3), updated with y, reset 0.
REQ-030 Without ITER_ROOT_UNIT_REMAINDER_EN port rem and its logic SHALL be absent; other behaviour identical.

Verification
REQ-031 WIDTH=8, on=1, x=13, start pulse -> b=1 for 4 cycles, s=4, y=3, done pulse, regime=1 (rem=4 if enabled).
REQ-032 WIDTH=8, on=2, x=200 -> y=5 after 3 iterations, s=3; x=255 on=1 -> y=15.
REQ-033 on=0, start=1 -> no launch, b=0, active=0, y unchanged; then on=3 x=13 -> y=13 after 1 iteration.
REQ-034 Sqrt launch, on=0 on second CALC cycle -> abort, b=0 next cycle, no done, y keeps previous value.
REQ-035 start held high, on=1, x changing -> consecutive ops with no gap, done every 5 cycles; rst mid-op -> all outputs 0.
REQ-036 WIDTH=16, on=1, x=65535 -> y=255 after 8 iterations; on=2, x=4096 -> y=16.

Source files
------------

// File: rtl/iter_root_unit.sv
// Iterative integer square root / cube root / pass-through unit, one result bit per cycle MSB-first.
// Optional remainder output enabled by defining ITER_ROOT_UNIT_REMAINDER_EN.
module iter_root_unit #(
    parameter  int WIDTH = 8,
    localparam int N_SQ  = WIDTH / 2,
    localparam int N_CB  = (WIDTH + 2) / 3,
    localparam int SW    = $clog2(N_SQ + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       on,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic [SW-1:0]    s,
    output logic             b,
    output logic             active,
    output logic [1:0]       regime,
    output logic             done
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] rem
`endif
);

    // Product width large enough that cand^3 never wraps for any candidate.
    localparam int PW = 3 * N_SQ;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  xr;
    logic [N_SQ-1:0]   acc, cand, acc_nx;
    logic [SW-1:0]     n_bits, n_iter, shamt;
    logic [PW-1:0]     cand_w, cand_sq, cand_cb, xr_w;
    logic              keep, launch, last;
    logic [WIDTH-1:0]  result;

    // Bit-resolution datapath: trial candidate, full-precision power, keep/drop decision.
    always_comb begin
        n_bits  = (regime == 2'd2) ? SW'(N_CB) : SW'(N_SQ);
        n_iter  = (regime == 2'd3) ? SW'(1) : n_bits;
        shamt   = n_bits - s - SW'(1);
        cand    = acc | (N_SQ'(1) << shamt);
        cand_w  = PW'(cand);
        cand_sq = cand_w * cand_w;
        cand_cb = cand_sq * cand_w;
        xr_w    = PW'(xr);
        keep    = (regime == 2'd2) ? (cand_cb <= xr_w) : (cand_sq <= xr_w);
        acc_nx  = keep ? cand : acc;
        result  = (regime == 2'd3) ? xr : WIDTH'(acc_nx);
    end

`ifdef ITER_ROOT_UNIT_REMAINDER_EN
    logic [PW-1:0]    root_w, root_pw, diff_w;
    logic [WIDTH-1:0] rem_nx;

    always_comb begin
        root_w  = PW'(acc_nx);
        root_pw = (regime == 2'd2) ? root_w * root_w * root_w : root_w * root_w;
        diff_w  = xr_w - root_pw;
        rem_nx  = (regime == 2'd3) ? '0 : diff_w[WIDTH-1:0];
    end
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_nx = state;
        b        = (state == CALC);
        done     = (state == DONE);
        launch   = start && (on != 2'd0) && (state == IDLE || state == DONE);
        last     = (s == n_iter - SW'(1));
        case (state)
            IDLE: if (launch) state_nx = CALC;
            CALC: begin
                if (on == 2'd0)
                    state_nx = IDLE;
                else if (last)
                    state_nx = DONE;
            end
            DONE:    state_nx = launch ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            s      <= '0;
            active <= 1'b0;
            regime <= 2'd0;
            xr     <= '0;
            acc    <= '0;
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
            rem    <= '0;
`endif
        end else begin
            active <= (on != 2'd0);
            if (launch) begin
                xr     <= x;
                regime <= on;
                s      <= '0;
                acc    <= '0;
            end else if (state == CALC && on != 2'd0) begin
                s   <= s + SW'(1);
                acc <= acc_nx;
                if (last) begin
                    y <= result;
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
                    rem <= rem_nx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_root_unit.sv
// Scoreboard bench for iter_root_unit: WIDTH=8 instance checked via queue on done, WIDTH=16 checked inline.
// Remainder checks are compiled in when ITER_ROOT_UNIT_REMAINDER_EN is defined.
module tb_iter_root_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, b, done, active;
    logic [1:0] on = 2'd0, regime;
    logic [7:0] x = 8'd0, y;
    logic [2:0] s;

    logic        start16 = 1'b0, b16, done16, active16;
    logic [1:0]  on16 = 2'd0, regime16;
    logic [15:0] x16 = 16'd0, y16;
    logic [3:0]  s16;
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
    logic [7:0]  rem;
    logic [15:0] rem16;
`endif

    always #5 clk = ~clk;

    iter_root_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .x(x), .on(on), .start(start), .y(y), .s(s), .b(b),
        .active(active), .regime(regime), .done(done)
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
        , .rem(rem)
`endif
    );

    iter_root_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .x(x16), .on(on16), .start(start16), .y(y16), .s(s16), .b(b16),
        .active(active16), .regime(regime16), .done(done16)
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
        , .rem(rem16)
`endif
    );

    typedef struct {
        logic [7:0] y;
        logic [2:0] s;
        logic [1:0] regime;
        logic [7:0] rem;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] last_y = 8'd0;

    function automatic longint ipow(longint v, int k);
        return (k == 3) ? v * v * v : v * v;
    endfunction

    function automatic longint iroot(longint v, int k);
        longint r = 0;
        while (ipow(r + 1, k) <= v) r++;
        return r;
    endfunction

    function automatic void push_exp(int mode, int val);
        exp_t e;
        longint r = (mode == 3) ? longint'(val) : iroot(longint'(val), mode + 1);
        e.y      = 8'(r);
        e.s      = (mode == 1) ? 3'd4 : (mode == 2) ? 3'd3 : 3'd1;
        e.regime = 2'(mode);
        e.rem    = (mode == 3) ? 8'd0 : 8'(longint'(val) - ipow(r, mode + 1));
        last_y   = e.y;
        sbq.push_back(e);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done y=%0d s=%0d", y, s);
            end else begin
                e = sbq.pop_front();
                if (y !== e.y || s !== e.s || regime !== e.regime) begin
                    bad++;
                    $display("FAIL result y=%0d s=%0d regime=%0d want y=%0d s=%0d regime=%0d",
                             y, s, regime, e.y, e.s, e.regime);
                end
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
                total++;
                if (rem !== e.rem) begin
                    bad++;
                    $display("FAIL rem got=%0d want=%0d", rem, e.rem);
                end
`endif
            end
        end
    end

    // One complete op with x/on disturbed (on kept nonzero) while computing.
    task automatic run_op(input int mode, input int val, input int n);
        int lat, bcnt;
        @(negedge clk);
        on = 2'(mode); x = 8'(val); start = 1'b1;
        push_exp(mode, val);
        @(negedge clk);
        start = 1'b0; lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (b) bcnt++;
            x  = 8'($urandom);
            on = (mode == 1) ? 2'd2 : 2'd1;
            @(negedge clk);
            lat++;
        end
        total++;
        if (!done || lat != n + 1 || bcnt != n) begin
            bad++;
            $display("FAIL op_timing mode=%0d x=%0d done=%0d lat=%0d busy=%0d want lat=%0d busy=%0d",
                     mode, val, done, lat, bcnt, n + 1, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (y !== 8'd0 || s !== 3'd0 || b !== 1'b0 || done !== 1'b0 || active !== 1'b0 ||
            regime !== 2'd0 || y16 !== 16'd0 || b16 !== 1'b0) begin
            bad++;
            $display("FAIL reset y=%0d s=%0d b=%0d done=%0d active=%0d regime=%0d want all 0",
                     y, s, b, done, active, regime);
        end
        rst = 1'b0;
    endtask

    task automatic test_modes();
        run_op(1, 13, 4);
        run_op(1, 255, 4);
        run_op(1, 0, 4);
        run_op(2, 200, 3);
        run_op(2, 255, 3);
        run_op(2, 0, 3);
        run_op(3, 13, 1);
    endtask

    task automatic test_off();
        @(negedge clk);
        on = 2'd0; x = 8'd99; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (b !== 1'b0 || active !== 1'b0 || done !== 1'b0 || y !== last_y) begin
                bad++;
                $display("FAIL off_start b=%0d active=%0d done=%0d y=%0d want 0 0 0 %0d",
                         b, active, done, y, last_y);
            end
        end
        start = 1'b0;
        run_op(3, 13, 1);
    endtask

    task automatic test_abort();
        run_op(1, 100, 4);
        @(negedge clk);
        on = 2'd1; x = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        on = 2'd0;
        @(negedge clk);
        total++;
        if (b !== 1'b0 || done !== 1'b0 || y !== 8'd10 || s !== 3'd1) begin
            bad++;
            $display("FAIL abort b=%0d done=%0d y=%0d s=%0d want 0 0 10 1", b, done, y, s);
        end
        repeat (5) @(negedge clk);
        total++;
        if (b !== 1'b0 || y !== 8'd10) begin
            bad++;
            $display("FAIL abort_hold b=%0d y=%0d want 0 10", b, y);
        end
    endtask

    task automatic test_back_to_back();
        int vals[4] = '{13, 200, 255, 0};
        int cyc;
        @(negedge clk);
        on = 2'd1; x = 8'(vals[0]); start = 1'b1;
        push_exp(1, vals[0]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc = 1;
            if (k > 0) begin
                total++;
                if (b !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_gap op=%0d b=%0d want 1", k, b);
                end
            end
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            total++;
            if (!done || cyc != 5) begin
                bad++;
                $display("FAIL b2b_period op=%0d done=%0d cycles=%0d want 5", k, done, cyc);
            end
            if (k < 3) begin
                x = 8'(vals[k + 1]);
                push_exp(1, vals[k + 1]);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (b !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle b=%0d want 0", b);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        on = 2'd1; x = 8'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        total++;
        if (y !== 8'd0 || s !== 3'd0 || b !== 1'b0 || done !== 1'b0 || active !== 1'b0 ||
            regime !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid y=%0d s=%0d b=%0d done=%0d active=%0d regime=%0d want all 0",
                     y, s, b, done, active, regime);
        end
        @(negedge clk);
        total++;
        if (b !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority b=%0d want 0", b);
        end
        rst = 1'b0; start = 1'b0;
        repeat (6) @(negedge clk);
        run_op(2, 27, 3);
    endtask

    task automatic test_wide();
        int modes[2] = '{1, 2};
        int xs[2]    = '{65535, 4096};
        int ys[2]    = '{255, 16};
        int ns[2]    = '{8, 6};
        int rems[2]  = '{510, 0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            on16 = 2'(modes[i]); x16 = 16'(xs[i]); start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0; lat = 1;
            while (!done16 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (!done16 || lat != ns[i] + 1 || y16 !== 16'(ys[i]) || s16 !== 4'(ns[i])) begin
                bad++;
                $display("FAIL wide mode=%0d done=%0d lat=%0d y=%0d s=%0d want lat=%0d y=%0d s=%0d",
                         modes[i], done16, lat, y16, s16, ns[i] + 1, ys[i], ns[i]);
            end
`ifdef ITER_ROOT_UNIT_REMAINDER_EN
            total++;
            if (rem16 !== 16'(rems[i])) begin
                bad++;
                $display("FAIL wide_rem got=%0d want=%0d", rem16, rems[i]);
            end
`else
            if (rems[i] < 0) $display("unreachable");
`endif
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_off();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        test_wide();
        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
